// File: rtl/spike_fanout_router.sv
// Spike fan-out router: edge capture, CSR lookup, one source per cycle.
// Define NI_EXT_PACKET_EN to emit off-tile destinations as packets.
module spike_fanout_router (
  input  logic         CLK,
  input  logic         clear,
  input  logic         spike0,
  input  logic         spike1,
  input  logic         spike2,
  input  logic         spike3,
  input  logic         spike4,
  input  logic         spike5,
  input  logic         spike6,
  input  logic         spike7,
  input  logic         spike8,
  input  logic         spike9,
  input  logic [119:0] neuron_addresses_initialization,
  input  logic [54:0]  connection_pointer_initialization,
  input  logic [359:0] downstream_connections_initialization,
  output logic [11:0]  spike_out_source0,
  output logic [11:0]  spike_out_source1,
  output logic [11:0]  spike_out_source2,
  output logic [11:0]  spike_out_source3,
  output logic [11:0]  spike_out_source4,
  output logic [11:0]  spike_out_source5,
  output logic [11:0]  spike_out_source6,
  output logic [11:0]  spike_out_source7,
  output logic [11:0]  spike_out_source8,
  output logic [11:0]  spike_out_source9,
  output logic         busy
`ifdef NI_EXT_PACKET_EN
  ,
  output logic [23:0]  packet_out,
  output logic         packet_valid
`endif
);

  localparam int NN = 10;
  localparam int AW = 12;
  localparam int MC = 30;
  localparam int PW = 5;
  localparam logic [AW-1:0] IDLE = 12'hFFF;

  logic [AW-1:0] r_addr [NN];
  logic [PW-1:0] r_ptr  [NN+1];
  logic [AW-1:0] r_conn [MC];
  logic [NN-1:0] r_prev;
  logic [NN-1:0] r_pending;
  logic [AW-1:0] r_out  [NN];

  logic [NN-1:0] w_spike;
  logic [3:0]    w_sel;
  logic          w_any;
  logic          w_local;
  logic          w_done;
  logic [PW-1:0] w_lo;
  logic [PW-1:0] w_hi;
  logic [MC-1:0] w_in_rng;
  logic [NN-1:0] w_match [MC];
  logic [NN-1:0] w_tgt;
  logic [NN-1:0] w_clr;

  function automatic logic [PW-1:0] clamp(input logic [PW-1:0] p);
    return (p > 5'd30) ? 5'd30 : p;
  endfunction

  assign w_spike = {spike9, spike8, spike7, spike6, spike5,
                    spike4, spike3, spike2, spike1, spike0};

  always_ff @(posedge CLK) begin
    if (clear) begin
      for (int i = 0; i < NN; i++)
        r_addr[i] <= neuron_addresses_initialization[NN*AW-1-AW*i -: AW];
      for (int i = 0; i < NN+1; i++)
        r_ptr[i] <= connection_pointer_initialization[(NN+1)*PW-1-PW*i -: PW];
      for (int k = 0; k < MC; k++)
        r_conn[k] <= downstream_connections_initialization[MC*AW-1-AW*k -: AW];
    end
  end

`ifdef NI_EXT_PACKET_EN
  logic          r_active;
  logic [3:0]    r_cur_s;
  logic [PW-1:0] r_cur_k;
  logic [23:0]   r_pkt;
  logic          r_pkt_v;
  logic [MC-1:0] w_ext;
  logic [PW-1:0] w_start;
  logic [PW-1:0] w_first;
  logic [PW-1:0] w_next;
  logic          w_found;
  logic          w_more;
`endif

  always_comb begin
    w_sel = '0;
    for (int i = NN-1; i >= 0; i--)
      if (r_pending[i]) w_sel = 4'(i);
`ifdef NI_EXT_PACKET_EN
    if (r_active) w_sel = r_cur_s;
`endif
  end

  assign w_any = |r_pending;
  assign w_lo  = clamp(r_ptr[w_sel]);
  assign w_hi  = clamp(r_ptr[w_sel + 4'd1]);

  always_comb begin
    for (int k = 0; k < MC; k++) begin
      w_in_rng[k] = (PW'(k) >= w_lo) && (PW'(k) < w_hi);
      for (int j = 0; j < NN; j++)
        w_match[k][j] = (r_conn[k] == r_addr[j]);
    end
  end

`ifdef NI_EXT_PACKET_EN
  assign w_local = w_any && !r_active;
`else
  assign w_local = w_any;
`endif

  // Duplicate entries simply OR into the same target bit.
  always_comb begin
    w_tgt = '0;
    for (int k = 0; k < MC; k++)
      for (int j = 0; j < NN; j++)
        w_tgt[j] = w_tgt[j] | (w_in_rng[k] & w_match[k][j]);
    if (!w_local) w_tgt = '0;
  end

`ifdef NI_EXT_PACKET_EN
  always_comb begin
    for (int k = 0; k < MC; k++)
      w_ext[k] = ~|w_match[k];
    w_start = r_active ? r_cur_k : w_lo;
    w_found = 1'b0;
    w_first = '0;
    for (int k = MC-1; k >= 0; k--)
      if (w_in_rng[k] && w_ext[k] && PW'(k) >= w_start) begin
        w_found = 1'b1;
        w_first = PW'(k);
      end
    w_more = 1'b0;
    w_next = '0;
    for (int k = MC-1; k >= 0; k--)
      if (w_found && w_in_rng[k] && w_ext[k] && PW'(k) > w_first) begin
        w_more = 1'b1;
        w_next = PW'(k);
      end
  end

  assign w_done = w_any && !(w_found && w_more);

  always_ff @(posedge CLK) begin
    if (clear) begin
      r_active <= 1'b0;
      r_cur_s  <= '0;
      r_cur_k  <= '0;
      r_pkt    <= '0;
      r_pkt_v  <= 1'b0;
    end else begin
      r_pkt_v <= w_any && w_found;
      r_pkt   <= (w_any && w_found) ? {r_addr[w_sel], r_conn[w_first]} : '0;
      if (w_any && w_found && w_more) begin
        r_active <= 1'b1;
        r_cur_s  <= w_sel;
        r_cur_k  <= w_next;
      end else begin
        r_active <= 1'b0;
      end
    end
  end

  assign packet_out   = r_pkt;
  assign packet_valid = r_pkt_v;
`else
  assign w_done = w_any;
`endif

  assign w_clr = w_done ? (NN'(1) << w_sel) : '0;

  // A re-spike of the finishing source survives: clear first, then OR edges.
  always_ff @(posedge CLK) begin
    if (clear) begin
      r_pending <= '0;
      r_prev    <= w_spike;
      for (int j = 0; j < NN; j++) r_out[j] <= IDLE;
    end else begin
      r_prev    <= w_spike;
      r_pending <= (r_pending & ~w_clr) | (w_spike & ~r_prev);
      for (int j = 0; j < NN; j++)
        r_out[j] <= w_tgt[j] ? r_addr[w_sel] : IDLE;
    end
  end

  assign busy = |r_pending;

  assign spike_out_source0 = r_out[0];
  assign spike_out_source1 = r_out[1];
  assign spike_out_source2 = r_out[2];
  assign spike_out_source3 = r_out[3];
  assign spike_out_source4 = r_out[4];
  assign spike_out_source5 = r_out[5];
  assign spike_out_source6 = r_out[6];
  assign spike_out_source7 = r_out[7];
  assign spike_out_source8 = r_out[8];
  assign spike_out_source9 = r_out[9];

endmodule

// File: tb/tb_spike_fanout_router.sv
// Bench for spike_fanout_router: queue/set model plus directed literals.
// Builds with or without NI_EXT_PACKET_EN.
module tb_spike_fanout_router;

  logic         CLK = 1'b0;
  logic         clear;
  logic [9:0]   sp;
  logic [119:0] addr_bus;
  logic [54:0]  ptr_bus;
  logic [359:0] conn_bus;
  logic [11:0]  o [10];
  logic         busy;
`ifdef NI_EXT_PACKET_EN
  logic [23:0]  packet_out;
  logic         packet_valid;
`endif

  always #5 CLK = ~CLK;

  spike_fanout_router dut (
    .CLK(CLK),
    .clear(clear),
    .spike0(sp[0]), .spike1(sp[1]), .spike2(sp[2]), .spike3(sp[3]),
    .spike4(sp[4]), .spike5(sp[5]), .spike6(sp[6]), .spike7(sp[7]),
    .spike8(sp[8]), .spike9(sp[9]),
    .neuron_addresses_initialization(addr_bus),
    .connection_pointer_initialization(ptr_bus),
    .downstream_connections_initialization(conn_bus),
    .spike_out_source0(o[0]), .spike_out_source1(o[1]),
    .spike_out_source2(o[2]), .spike_out_source3(o[3]),
    .spike_out_source4(o[4]), .spike_out_source5(o[5]),
    .spike_out_source6(o[6]), .spike_out_source7(o[7]),
    .spike_out_source8(o[8]), .spike_out_source9(o[9]),
    .busy(busy)
`ifdef NI_EXT_PACKET_EN
    ,
    .packet_out(packet_out),
    .packet_valid(packet_valid)
`endif
  );

  logic [11:0] cfg_addr [10];
  logic [4:0]  cfg_ptr  [11];
  logic [11:0] cfg_conn [30];

  int n_checks = 0;
  int n_errors = 0;
  bit en = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: set of pending sources, min picked, CSR walked directly.
  logic [11:0] e_out [10];
  logic        e_busy;
  logic [23:0] e_pkt;
  logic        e_pv;
  logic [9:0]  m_pend;
  logic [9:0]  m_prev;
  int          m_xq[$];
  int          m_cur;

  always @(posedge CLK) begin
    logic [9:0] edges;
    int s, lo, hi;
    bit hit;
    for (int j = 0; j < 10; j++) e_out[j] = 12'hFFF;
    e_pkt = '0;
    e_pv  = 1'b0;
    if (clear) begin
      m_pend = '0;
      m_prev = sp;
      m_xq.delete();
    end else begin
      edges  = sp & ~m_prev;
      m_prev = sp;
      if (m_xq.size() > 0) begin
        e_pkt = {cfg_addr[m_cur], cfg_conn[m_xq.pop_front()]};
        e_pv  = 1'b1;
        if (m_xq.size() == 0) m_pend[m_cur] = 1'b0;
      end else if (m_pend != 0) begin
        s = 0;
        while (!m_pend[s]) s++;
        lo = (cfg_ptr[s] > 30) ? 30 : int'(cfg_ptr[s]);
        hi = (cfg_ptr[s+1] > 30) ? 30 : int'(cfg_ptr[s+1]);
        for (int k = lo; k < hi; k++) begin
          hit = 0;
          for (int j = 0; j < 10; j++)
            if (cfg_conn[k] == cfg_addr[j]) begin
              e_out[j] = cfg_addr[s];
              hit = 1;
            end
          if (!hit) m_xq.push_back(k);
        end
`ifdef NI_EXT_PACKET_EN
        if (m_xq.size() > 0) begin
          e_pkt = {cfg_addr[s], cfg_conn[m_xq.pop_front()]};
          e_pv  = 1'b1;
        end
        if (m_xq.size() == 0) m_pend[s] = 1'b0;
        else m_cur = s;
`else
        m_xq.delete();
        m_pend[s] = 1'b0;
`endif
      end
      m_pend = m_pend | edges;
    end
    e_busy = |m_pend;
  end

  always @(negedge CLK) begin
    if (en) begin
      for (int j = 0; j < 10; j++)
        chk($sformatf("cyc_out%0d", j), 32'(o[j]), 32'(e_out[j]));
      chk("cyc_busy", 32'(busy), 32'(e_busy));
`ifdef NI_EXT_PACKET_EN
      chk("cyc_pv", 32'(packet_valid), 32'(e_pv));
      chk("cyc_pkt", 32'(packet_out), 32'(e_pkt));
`endif
    end
  end

  task automatic tick();
    @(negedge CLK);
  endtask

  initial begin
    logic [4:0]  pv [11];
    logic [11:0] cv [19];
    pv = '{0, 3, 5, 8, 10, 12, 14, 15, 17, 18, 19};
    cv = '{3, 5, 7, 4, 6, 4, 5, 6, 8, 9, 8, 9, 8, 9, 9, 8, 9,
           12'hFFB, 12'hFFC};
    for (int i = 0; i < 10; i++) cfg_addr[i] = 12'(i);
    for (int i = 0; i < 11; i++) cfg_ptr[i] = pv[i];
    for (int k = 0; k < 30; k++) cfg_conn[k] = (k < 19) ? cv[k] : 12'd0;
    for (int i = 0; i < 10; i++) addr_bus[119-12*i -: 12] = cfg_addr[i];
    for (int i = 0; i < 11; i++) ptr_bus[54-5*i -: 5] = cfg_ptr[i];
    for (int k = 0; k < 30; k++) conn_bus[359-12*k -: 12] = cfg_conn[k];

    sp = '0;
    clear = 1'b1;
    repeat (2) tick();
    en = 1;
    chk("rst_out0", 32'(o[0]), 32'hFFF);
    chk("rst_out9", 32'(o[9]), 32'hFFF);
    chk("rst_busy", 32'(busy), 32'd0);
    clear = 1'b0;
    tick();

    sp[0] = 1'b1;
    tick();
    chk("s0_busy", 32'(busy), 32'd1);
    tick();
    chk("s0_out3", 32'(o[3]), 32'd0);
    chk("s0_out5", 32'(o[5]), 32'd0);
    chk("s0_out7", 32'(o[7]), 32'd0);
    chk("s0_out4", 32'(o[4]), 32'hFFF);
    tick();
    chk("s0_after", 32'(o[3]), 32'hFFF);
    repeat (3) tick();
    chk("s0_hold_out3", 32'(o[3]), 32'hFFF);
    chk("s0_hold_busy", 32'(busy), 32'd0);

    sp = '0;
    tick();
    sp[0] = 1'b1;
    sp[2] = 1'b1;
    tick();
    chk("s02_busy1", 32'(busy), 32'd1);
    tick();
    chk("s02_c1_out3", 32'(o[3]), 32'd0);
    chk("s02_c1_out4", 32'(o[4]), 32'hFFF);
    chk("s02_busy2", 32'(busy), 32'd1);
    tick();
    chk("s02_c2_out4", 32'(o[4]), 32'd2);
    chk("s02_c2_out5", 32'(o[5]), 32'd2);
    chk("s02_c2_out6", 32'(o[6]), 32'd2);
    chk("s02_c2_out3", 32'(o[3]), 32'hFFF);
    chk("s02_busy_end", 32'(busy), 32'd0);
    tick();

    sp = '0;
    tick();
    sp[5:3] = 3'b111;
    tick();
    tick();
    chk("s345_a8", 32'(o[8]), 32'd3);
    chk("s345_a9", 32'(o[9]), 32'd3);
    tick();
    chk("s345_b8", 32'(o[8]), 32'd4);
    chk("s345_b9", 32'(o[9]), 32'd4);
    tick();
    chk("s345_c8", 32'(o[8]), 32'd5);
    chk("s345_c9", 32'(o[9]), 32'd5);
    tick();
    chk("s345_idle", 32'(o[8]), 32'hFFF);

    sp = '0;
    tick();
    sp[8] = 1'b1;
    tick();
    chk("s8_busy1", 32'(busy), 32'd1);
    tick();
    chk("s8_busy0", 32'(busy), 32'd0);
    chk("s8_out8", 32'(o[8]), 32'hFFF);
    chk("s8_out9", 32'(o[9]), 32'hFFF);
`ifdef NI_EXT_PACKET_EN
    chk("s8_pv", 32'(packet_valid), 32'd1);
    chk("s8_pkt", 32'(packet_out), 32'h008FFB);
`endif
    tick();

    sp = '0;
    tick();
    sp[0] = 1'b1;
    sp[2] = 1'b1;
    sp[7] = 1'b1;
    tick();
    clear = 1'b1;
    tick();
    chk("clr_out3", 32'(o[3]), 32'hFFF);
    chk("clr_out4", 32'(o[4]), 32'hFFF);
    chk("clr_busy", 32'(busy), 32'd0);
    clear = 1'b0;
    repeat (4) tick();
    chk("clr_hold_out3", 32'(o[3]), 32'hFFF);
    chk("clr_hold_out8", 32'(o[8]), 32'hFFF);
    chk("clr_hold_busy", 32'(busy), 32'd0);

    en = 0;
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/spike_fanout_router.md
# spike_fanout_router

Local spike-distribution network interface for a 10-neuron SNN accelerator tile. It captures spike events from the per-neuron potential adders and looks up each spiking neuron's downstream connections in a CSR table (row pointers plus destination addresses). It then presents the spiking neuron's 12-bit address on the source port of every local destination neuron, which feeds that neuron's weight-accumulating MAC. Sources are serialized one per cycle, so no destination ever sees two sources in the same cycle.

## Interface
- N_NEURONS, 10: local neurons (ports below are fixed for 10).
- ADDR_W, 12: neuron address width.
- MAX_CONN, 30: CSR connection slots.
- PTR_W, 5: CSR pointer width.
- IDLE_ADDR, 12'hFFF: "no spike" value on output ports.
- CLK  in  1  sole clock, rising edge.
- clear  in  1  synchronous active-high reset; also loads configuration (timestep clear).
- spike0..spike9  in  1 each  level spike flags from potential adders.
- neuron_addresses_initialization  in  120  addr[i] at bits [119-12i -: 12] (neuron 0 in MSBs).
- connection_pointer_initialization  in  55  ptr[i], i=0..10, at [54-5i -: 5].
- downstream_connections_initialization  in  360  conn[k], k=0..29, at [359-12k -: 12].
- spike_out_source0..spike_out_source9  out  12 each  source address delivered to neuron j's MAC.
- busy  out  1  high while any spike is pending or being emitted.

## Operation
- Configuration registers (addr, ptr, conn) load from the initialization buses on every cycle with clear=1 and are held while clear=0.
- Edge capture: prev_spike[i] is registered each cycle. When spike_i=1 and prev_spike[i]=0, pending[i] is set. A held-high spike does not re-trigger.
- Scheduler: when not clear, the lowest-index pending source s is selected each cycle.
  - Fan-out is conn[ptr[s]] .. conn[ptr[s+1]-1].
  - If ptr[s+1] <= ptr[s], s has no fan-out.
  - Pointers greater than 30 are clamped to 30.
- Destination resolution: each conn[k] is compared against all addr[j]. On a match, spike_out_source{j} is loaded with addr[s] for one cycle. Non-matching destinations are external (see Configuration).
- Outputs whose neuron is not targeted in a cycle load IDLE_ADDR.
- If a fan-out entry is duplicated, the destination receives addr[s] once.
- When emission of s completes, pending[s] is cleared in that cycle. New edges arriving in the same cycle are ORed into pending. A re-spike of s in its own completion cycle keeps pending[s] set.
- busy = |pending or emission in progress.

## Timing
- Reset (clear=1): all spike_out_source* = 12'hFFF, pending = 0, prev_spike <= current spike inputs, busy = 0, external packet port idle. Spike edges coincident with clear are discarded.
- Spike rising edge sampled at posedge k sets pending at k. Emission appears on the outputs after posedge k+1.
- Local fan-out of one source completes in one cycle.
- Sources are serialized lowest index first, one per cycle.
- m simultaneous spikes complete after posedge k+m (local-only fan-out).
- Each output value is valid exactly one cycle, then returns to FFF unless the next source also targets it.
- clear mid-scan aborts: pending spikes are dropped and outputs go FFF on the next edge.

## Configuration
- NI_EXT_PACKET_EN defined:
  - Adds ports packet_out out 24 = {src_addr, dest_addr} and packet_valid out 1, both reset to 0.
  - External destinations of source s are emitted one per cycle in CSR order.
  - The first external packet is emitted in the same cycle as s's local fan-out.
  - pending[s] clears in the cycle of its last external packet; the scheduler holds on s until then.
- NI_EXT_PACKET_EN undefined: no extra ports; external destinations are silently dropped and every source takes one cycle.

## Test plan
Common configuration for all cases: addr[i]=i; ptr = {0,3,5,8,10,12,14,15,17,18,19}; conn = {3,5,7, 4,6, 4,5,6, 8,9, 8,9, 8,9, 9, 8,9, FFB, FFC, 0…}.
- Reset: clear pulse with all spikes low -> all outputs FFF, busy=0.
- spike0 rises -> one cycle later outputs 3, 5 and 7 = 12'd0, all others FFF. The next cycle all are FFF. Holding spike0 high does not re-emit.
- spike0 and spike2 rise together -> cycle 1: outputs 3, 5, 7 = 0. Cycle 2: outputs 4, 5, 6 = 2. busy high for 2 cycles.
- spike3, spike4 and spike5 rise together -> output 8 and output 9 carry 3, 4, 5 on three consecutive cycles.
- External destinations (both builds): spike8 rises.
  - With NI_EXT_PACKET_EN: packet_out = {12'd8, 12'hFFB} with packet_valid for one cycle.
  - Without it: no output changes, and busy clears after one cycle.
- clear asserted in the cycle after spikes 0, 2 and 7 rise -> next edge all outputs FFF and pending = 0. Spikes held high afterwards do not emit.
